// File: rtl/wb_cmd_master.sv
// ============================================================================
// Module      : wb_cmd_master
// Description : Wishbone classic master. Runs host commands from a FIFO as
//               single bus cycles and returns one response per command.
//               It also latches rising edges of the slave interrupt line.
//               Optional macro WB_CMD_TIMEOUT_EN enables the REQ timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_cmd_master #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-1:0]   cmd_adr_i,
    input  logic [DATA_W-1:0]   cmd_dat_i,
    input  logic [DATA_W/8-1:0] cmd_sel_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_dat_o,
    output logic                rsp_err_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                int_i,
    output logic                int_pending_o,
    input  logic                int_clr_i,
    output logic                busy_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    if ((DATA_W % 8) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("wb_cmd_master: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Command FIFO; pointers carry one extra wrap bit to tell full from empty.
    logic              fifo_we  [DEPTH];
    logic [ADDR_W-1:0] fifo_adr [DEPTH];
    logic [DATA_W-1:0] fifo_dat [DEPTH];
    logic [SEL_W-1:0]  fifo_sel [DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              empty, full, push, pop;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign cmd_ready_o = !full && wb_rst_i;
    assign push        = cmd_valid_i && cmd_ready_o;

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_we [wr_ptr[PTR_W-1:0]] <= cmd_we_i;
            fifo_adr[wr_ptr[PTR_W-1:0]] <= cmd_adr_i;
            fifo_dat[wr_ptr[PTR_W-1:0]] <= cmd_dat_i;
            fifo_sel[wr_ptr[PTR_W-1:0]] <= cmd_sel_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    logic              cyc, cyc_nxt, we_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [ADDR_W-1:0] adr_nxt;
    logic [DATA_W-1:0] dat_nxt, rsp_dat_nxt;
    logic [SEL_W-1:0]  sel_nxt;

`ifdef WB_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    logic [CNT_W-1:0] to_cnt, to_cnt_nxt;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) to_cnt <= '0;
        else           to_cnt <= to_cnt_nxt;
    end
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        cyc_nxt       = cyc;
        adr_nxt       = wb_adr_o;
        dat_nxt       = wb_dat_o;
        sel_nxt       = wb_sel_o;
        we_nxt        = wb_we_o;
        rsp_valid_nxt = rsp_valid_o;
        rsp_dat_nxt   = rsp_dat_o;
        rsp_err_nxt   = rsp_err_o;
`ifdef WB_CMD_TIMEOUT_EN
        to_cnt_nxt    = to_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    adr_nxt   = fifo_adr[rd_ptr[PTR_W-1:0]];
                    we_nxt    = fifo_we[rd_ptr[PTR_W-1:0]];
                    dat_nxt   = fifo_we[rd_ptr[PTR_W-1:0]] ? fifo_dat[rd_ptr[PTR_W-1:0]] : '0;
                    sel_nxt   = fifo_sel[rd_ptr[PTR_W-1:0]];
                    cyc_nxt   = 1'b1;
                    state_nxt = ST_REQ;
`ifdef WB_CMD_TIMEOUT_EN
                    to_cnt_nxt = '0;
`endif
                end
            end
            ST_REQ: begin
                if (wb_ack_i) begin
                    cyc_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_dat_nxt   = wb_we_o ? '0 : wb_dat_i;
                    rsp_err_nxt   = 1'b0;
                    state_nxt     = ST_RSP;
                end
`ifdef WB_CMD_TIMEOUT_EN
                else if (to_cnt == CNT_LAST) begin
                    cyc_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_dat_nxt   = '0;
                    rsp_err_nxt   = 1'b1;
                    state_nxt     = ST_RSP;
                end else begin
                    to_cnt_nxt = to_cnt + CNT_ONE;
                end
`endif
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            cyc         <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            wb_we_o     <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            cyc         <= cyc_nxt;
            wb_adr_o    <= adr_nxt;
            wb_dat_o    <= dat_nxt;
            wb_sel_o    <= sel_nxt;
            wb_we_o     <= we_nxt;
            rsp_valid_o <= rsp_valid_nxt;
            rsp_dat_o   <= rsp_dat_nxt;
            rsp_err_o   <= rsp_err_nxt;
        end
    end

    assign wb_cyc_o = cyc;
    assign wb_stb_o = cyc;
    assign busy_o   = !empty || (state != ST_IDLE);

    // A fresh rising edge beats a simultaneous clear.
    logic int_prev;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            int_prev      <= 1'b0;
            int_pending_o <= 1'b0;
        end else begin
            int_prev <= int_i;
            if (int_i && !int_prev) int_pending_o <= 1'b1;
            else if (int_clr_i)     int_pending_o <= 1'b0;
        end
    end

endmodule

`default_nettype wire
